ip_hash_table: RTL and testbench

Parametrised, set-associative exact-match table for IP addresses (or any fixed-width key) supporting lookup, insert and delete, with a sequenced flush after reset or on request. It is the next generation of the single-function IP hash controller. It adds configurable key width, bucket count and associativity, a ready/valid command handshake, explicit per-operation status and an occupancy counter. It sits behind the header parser and serves the filter/forwarding logic.

---
 rtl/data_valid_if.sv | 10 +
 rtl/ip_hash_table.sv | 186 ++++++++++++++++++
 tb/tb_ip_hash_table.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_valid_if.sv
// Result bus: a one-cycle valid pulse carrying a DATA_W-bit payload.
interface data_valid_if #(
    parameter int unsigned DATA_W = 2
);
    logic              valid;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data);
    modport slave  (input valid, input data);
endinterface

// File: rtl/ip_hash_table.sv
// ip_hash_table: set-associative exact-match key table (lookup/insert/delete) with a
// bucket-sequenced flush and an occupancy counter.
module ip_hash_table #(
    parameter int unsigned KEY_W   = 32,
    parameter int unsigned BUCKETS = 64,
    parameter int unsigned WAYS    = 4,
    parameter int unsigned CNT_W   = $clog2(BUCKETS * WAYS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid_i,
    input  logic [1:0]       op_i,
    input  logic [KEY_W-1:0] key_i,
    input  logic             flush_i,
    output logic             ready_o,
    data_valid_if.master     res_if_o,
    output logic [CNT_W-1:0] entries_o
);
    localparam int unsigned IDX_W  = $clog2(BUCKETS);
    localparam int unsigned NCHUNK = (KEY_W + IDX_W - 1) / IDX_W;
    localparam int unsigned PAD_W  = NCHUNK * IDX_W;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [1:0]       OpInsert   = 2'd1;
    localparam logic [1:0]       OpDelete   = 2'd2;
    localparam logic [IDX_W-1:0] LastBucket = IDX_W'(BUCKETS - 1);

    typedef enum logic [2:0] {StFlush, StIdle, StRead, StUpdate, StResp} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [1:0]       op_q;
    logic [KEY_W-1:0] key_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] entries_q;
    logic [1:0]       res_data_q;

    logic [WAYS-1:0]  tbl_valid_q [BUCKETS];
    logic [KEY_W-1:0] tbl_key_q   [BUCKETS][WAYS];
    logic [WAYS-1:0]  row_valid_q;
    logic [KEY_W-1:0] row_key_q   [WAYS];

    logic             accept;
    logic             start_flush;
    logic             hit;
    logic             has_free;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] free_way;
    logic             found;
    logic             ok;
    logic             wr_ins;
    logic             wr_del;

    // Zero-pad the key to whole IDX_W chunks and XOR the chunks together.
    function automatic logic [IDX_W-1:0] fold_key(input logic [KEY_W-1:0] k);
        logic [PAD_W-1:0] padded;
        logic [IDX_W-1:0] h;
        padded = PAD_W'(k);
        h      = '0;
        for (int i = 0; i < int'(NCHUNK); i++) begin
            h = h ^ padded[i*IDX_W +: IDX_W];
        end
        return h;
    endfunction

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        accept      = 1'b0;
        start_flush = 1'b0;
        unique case (state_q)
            StFlush: begin
                flush_cnt_d = flush_cnt_q + 1'b1;
                if (flush_cnt_q == LastBucket) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (flush_i) begin
                    state_d     = StFlush;
                    start_flush = 1'b1;
                    flush_cnt_d = '0;
                end else if (op_valid_i) begin
                    state_d = StRead;
                    accept  = 1'b1;
                end
            end
            StRead:   state_d = StUpdate;
            StUpdate: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StFlush;
        endcase
    end

    // Descending scan so the lowest-index way wins for both hit and free slot.
    always_comb begin
        hit      = 1'b0;
        has_free = 1'b0;
        hit_way  = '0;
        free_way = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (row_valid_q[w] && (row_key_q[w] == key_q)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!row_valid_q[w]) begin
                has_free = 1'b1;
                free_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        found  = hit;
        ok     = hit;
        wr_ins = 1'b0;
        wr_del = 1'b0;
        if (op_q == OpInsert) begin
            ok     = hit | has_free;
            wr_ins = ~hit & has_free;
        end else if (op_q == OpDelete) begin
            wr_del = hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFlush;
            flush_cnt_q <= '0;
            entries_q   <= '0;
            res_data_q  <= '0;
            op_q        <= '0;
            key_q       <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            if (start_flush) begin
                entries_q <= '0;
            end
            if (accept) begin
                op_q  <= op_i;
                key_q <= key_i;
                idx_q <= fold_key(key_i);
            end
            if (state_q == StUpdate) begin
                res_data_q <= {ok, found};
                if (wr_ins) begin
                    entries_q <= entries_q + 1'b1;
                end else if (wr_del) begin
                    entries_q <= entries_q - 1'b1;
                end
            end
        end
    end

    // Table storage carries no reset: the flush sequence clears every valid bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StFlush) begin
                tbl_valid_q[flush_cnt_q] <= '0;
            end
            if (state_q == StRead) begin
                row_valid_q <= tbl_valid_q[idx_q];
                for (int w = 0; w < int'(WAYS); w++) begin
                    row_key_q[w] <= tbl_key_q[idx_q][w];
                end
            end
            if (state_q == StUpdate) begin
                if (wr_ins) begin
                    tbl_valid_q[idx_q][free_way] <= 1'b1;
                    tbl_key_q[idx_q][free_way]   <= key_q;
                end
                if (wr_del) begin
                    tbl_valid_q[idx_q][hit_way] <= 1'b0;
                end
            end
        end
    end

    assign ready_o        = !rst && (state_q == StIdle);
    assign res_if_o.valid = !rst && (state_q == StResp);
    assign res_if_o.data  = rst ? 2'b00 : res_data_q;
    assign entries_o      = rst ? '0 : entries_q;

endmodule

// File: tb/tb_ip_hash_table.sv
// Self-checking bench for ip_hash_table: scoreboard queue of expected {ok, found} results.
module tb_ip_hash_table;
    localparam logic [1:0] OpLookup = 2'd0;
    localparam logic [1:0] OpInsert = 2'd1;
    localparam logic [1:0] OpDelete = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid_i;
    logic [1:0]  op_i;
    logic [31:0] key_i;
    logic        flush_i;
    logic        ready_o;
    logic [8:0]  entries_o;

    data_valid_if #(.DATA_W(2)) res_if ();

    ip_hash_table dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid_i (op_valid_i),
        .op_i       (op_i),
        .key_i      (key_i),
        .flush_i    (flush_i),
        .ready_o    (ready_o),
        .res_if_o   (res_if),
        .entries_o  (entries_o)
    );

    always #5 clk = ~clk;

    int         n_total = 0;
    int         n_bad = 0;
    int         exp_entries = 0;
    logic [1:0] exp_q [$];

    // Drives one command through the handshake and waits for its result pulse.
    task automatic send(input logic [1:0] op, input logic [31:0] key,
                        output logic [1:0] data, output int lat, output bit timeout);
        int n;
        n = 0;
        timeout = 1'b0;
        @(negedge clk);
        while (!ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout = 1'b1;
        op_valid_i = 1'b1;
        op_i       = op;
        key_i      = key;
        @(negedge clk);
        op_valid_i = 1'b0;
        lat = 1;
        while (!res_if.valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!res_if.valid) timeout = 1'b1;
        data = res_if.data;
    endtask

    task automatic test_reset();
        int         lowc;
        logic [1:0] got;
        logic [1:0] exp;
        int         lat;
        bit         to;
        rst = 1'b1; op_valid_i = 1'b0; flush_i = 1'b0; op_i = '0; key_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (ready_o !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", ready_o); end
        n_total++;
        if (res_if.valid !== 1'b0 || res_if.data !== 2'b00) begin
            n_bad++; $display("FAIL rst_res: got %b/%b want 0/00", res_if.valid, res_if.data);
        end
        n_total++;
        if (entries_o !== 9'd0) begin n_bad++; $display("FAIL rst_entries: got %0d want 0", entries_o); end
        @(posedge clk);
        #1 rst = 1'b0;
        exp_entries = 0;
        lowc = 0;
        @(negedge clk);
        while (!ready_o && lowc < 200) begin
            lowc++;
            @(negedge clk);
        end
        n_total++;
        if (lowc != 64) begin n_bad++; $display("FAIL rst_flush_len: got %0d want 64", lowc); end
        n_total++;
        if (entries_o !== 9'd0) begin n_bad++; $display("FAIL rst_flush_entries: got %0d want 0", entries_o); end
        exp_q.push_back(2'b00);
        send(OpLookup, 32'hC0A80001, got, lat, to);
        exp = exp_q.pop_front();
        n_total++;
        if (to || got !== exp) begin n_bad++; $display("FAIL rst_lookup: got %b want %b", got, exp); end
    endtask

    task automatic test_insert_lookup();
        logic [1:0]  ops  [3] = '{OpInsert, OpLookup, OpInsert};
        logic [1:0]  exps [3] = '{2'b10, 2'b11, 2'b11};
        logic [1:0]  got;
        logic [1:0]  exp;
        int          lat;
        bit          to;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(exps[i]);
            send(ops[i], 32'hC0A80001, got, lat, to);
            exp = exp_q.pop_front();
            if (i == 0) exp_entries++;
            n_total++;
            if (to || got !== exp) begin n_bad++; $display("FAIL ins_lkp_%0d: got %b want %b", i, got, exp); end
            n_total++;
            if (entries_o !== 9'(exp_entries)) begin
                n_bad++; $display("FAIL ins_lkp_entries_%0d: got %0d want %0d", i, entries_o, exp_entries);
            end
            if (i == 0) begin
                n_total++;
                if (lat != 3) begin n_bad++; $display("FAIL ins_latency: got %0d want 3", lat); end
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] keys [6] = '{32'h41, 32'h82, 32'hC3, 32'h104, 32'h145, 32'h145};
        logic [1:0]  ops  [6] = '{OpInsert, OpInsert, OpInsert, OpInsert, OpInsert, OpLookup};
        logic [1:0]  exps [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        logic [1:0]  got;
        logic [1:0]  exp;
        int          lat;
        bit          to;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(exps[i]);
            send(ops[i], keys[i], got, lat, to);
            exp = exp_q.pop_front();
            if (i < 4) exp_entries++;
            n_total++;
            if (to || got !== exp) begin n_bad++; $display("FAIL ovf_%0d: got %b want %b", i, got, exp); end
            n_total++;
            if (entries_o !== 9'(exp_entries)) begin
                n_bad++; $display("FAIL ovf_entries_%0d: got %0d want %0d", i, entries_o, exp_entries);
            end
        end
    endtask

    task automatic test_delete_reuse();
        logic [31:0] keys [5] = '{32'h82, 32'h145, 32'h145, 32'h82, 32'h82};
        logic [1:0]  ops  [5] = '{OpDelete, OpInsert, OpLookup, OpLookup, OpDelete};
        logic [1:0]  exps [5] = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b00};
        int          delta [5] = '{-1, 1, 0, 0, 0};
        logic [1:0]  got;
        logic [1:0]  exp;
        int          lat;
        bit          to;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(exps[i]);
            send(ops[i], keys[i], got, lat, to);
            exp = exp_q.pop_front();
            exp_entries += delta[i];
            n_total++;
            if (to || got !== exp) begin n_bad++; $display("FAIL del_%0d: got %b want %b", i, got, exp); end
            n_total++;
            if (entries_o !== 9'(exp_entries)) begin
                n_bad++; $display("FAIL del_entries_%0d: got %0d want %0d", i, entries_o, exp_entries);
            end
        end
    endtask

    task automatic test_flush_priority();
        int         n;
        int         lowc;
        logic [1:0] got;
        logic [1:0] exp;
        int         lat;
        bit         to;
        n = 0;
        @(negedge clk);
        while (!ready_o && n < 200) begin @(negedge clk); n++; end
        flush_i = 1'b1; op_valid_i = 1'b1; op_i = OpInsert; key_i = 32'h7777;
        @(negedge clk);
        flush_i = 1'b0; op_valid_i = 1'b0;
        exp_entries = 0;
        lowc = 0;
        while (!ready_o && lowc < 200) begin
            lowc++;
            @(negedge clk);
        end
        n_total++;
        if (lowc != 64) begin n_bad++; $display("FAIL flush_len: got %0d want 64", lowc); end
        n_total++;
        if (entries_o !== 9'd0) begin n_bad++; $display("FAIL flush_entries: got %0d want 0", entries_o); end
        exp_q.push_back(2'b00);
        send(OpLookup, 32'h7777, got, lat, to);
        exp = exp_q.pop_front();
        n_total++;
        if (to || got !== exp) begin n_bad++; $display("FAIL flush_op_dropped: got %b want %b", got, exp); end
        exp_q.push_back(2'b00);
        send(OpLookup, 32'hC0A80001, got, lat, to);
        exp = exp_q.pop_front();
        n_total++;
        if (to || got !== exp) begin n_bad++; $display("FAIL flush_cleared: got %b want %b", got, exp); end
    endtask

    task automatic test_reset_mid_op();
        int         n;
        bit         seen;
        logic [1:0] got;
        logic [1:0] exp;
        int         lat;
        bit         to;
        n = 0;
        seen = 1'b0;
        @(negedge clk);
        while (!ready_o && n < 200) begin @(negedge clk); n++; end
        op_valid_i = 1'b1; op_i = OpInsert; key_i = 32'hABCD;
        @(negedge clk);
        op_valid_i = 1'b0;
        seen |= res_if.valid;
        @(negedge clk);
        rst = 1'b1;
        seen |= res_if.valid;
        repeat (2) begin
            @(negedge clk);
            seen |= res_if.valid;
        end
        @(posedge clk);
        #1 rst = 1'b0;
        exp_entries = 0;
        n = 0;
        @(negedge clk);
        while (!ready_o && n < 200) begin
            seen |= res_if.valid;
            @(negedge clk);
            n++;
        end
        n_total++;
        if (seen !== 1'b0 || n >= 200) begin
            n_bad++; $display("FAIL midrst_no_result: got valid_seen=%b wait=%0d want 0 <200", seen, n);
        end
        exp_q.push_back(2'b00);
        send(OpLookup, 32'hABCD, got, lat, to);
        exp = exp_q.pop_front();
        n_total++;
        if (to || got !== exp) begin n_bad++; $display("FAIL midrst_absent: got %b want %b", got, exp); end
        n_total++;
        if (entries_o !== 9'd0) begin n_bad++; $display("FAIL midrst_entries: got %0d want 0", entries_o); end
    endtask

    task automatic test_back_to_back();
        int         nacc;
        int         nres;
        int         cyc;
        int         last_acc;
        logic [1:0] exp;
        nacc = 0; nres = 0; cyc = 0; last_acc = -1;
        @(negedge clk);
        op_valid_i = 1'b1; op_i = OpInsert; key_i = 32'h1000;
        while (nres < 8 && cyc < 200) begin
            if (res_if.valid) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL b2b_extra_result: got %b want none", res_if.data);
                end else begin
                    exp = exp_q.pop_front();
                    if (res_if.data !== exp) begin
                        n_bad++; $display("FAIL b2b_res_%0d: got %b want %b", nres, res_if.data, exp);
                    end
                end
                nres++;
            end
            if (ready_o && op_valid_i && nacc < 8) begin
                exp_q.push_back(nacc < 4 ? 2'b10 : 2'b11);
                if (nacc < 4) exp_entries++;
                if (last_acc >= 0) begin
                    n_total++;
                    if (cyc - last_acc != 4) begin
                        n_bad++; $display("FAIL b2b_spacing_%0d: got %0d want 4", nacc, cyc - last_acc);
                    end
                end
                last_acc = cyc;
                nacc++;
            end else if (nacc < 8) begin
                op_i  = (nacc < 4) ? OpInsert : ((nacc == 7) ? 2'd3 : OpLookup);
                key_i = 32'h1000 | 32'(nacc % 4);
            end else begin
                op_valid_i = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        op_valid_i = 1'b0;
        n_total++;
        if (nres != 8 || nacc != 8 || exp_q.size() != 0) begin
            n_bad++; $display("FAIL b2b_count: got acc=%0d res=%0d left=%0d want 8 8 0", nacc, nres, exp_q.size());
        end
        n_total++;
        if (entries_o !== 9'(exp_entries)) begin
            n_bad++; $display("FAIL b2b_entries: got %0d want %0d", entries_o, exp_entries);
        end
    endtask

    initial begin
        test_reset();
        test_insert_lookup();
        test_overflow();
        test_delete_reuse();
        test_flush_priority();
        test_reset_mid_op();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
